// File: rtl/processador_param_if.sv
// rtl/processador_param_if.sv - program memory port between the CPU and its synchronous instruction store
interface processador_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0]   prog_addr;
    logic [DATA_W+3:0]   prog_data;

    modport master (
        output prog_addr,
        input  prog_data
    );

    modport slave (
        input  prog_addr,
        output prog_data
    );
endinterface

// File: rtl/processador_param.sv
// rtl/processador_param.sv - parametrised multi-cycle accumulator CPU with run/step control and HALT
module processador_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    processador_param_if.master  prog,
    output logic                 halted,
    output logic [DATA_W-1:0]    debug_A,
    output logic [DATA_W-1:0]    debug_B,
    output logic [ADDR_W-1:0]    debug_PC,
    output logic [3:0]           debug_State,
    output logic [1:0]           debug_flags
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_WAIT   = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_HALT   = 4'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_MOVB = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W+3:0]   r_ir;
    logic                r_c;
    logic                r_z;

    logic [3:0]          w_op;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_res;
    logic                w_res_c;
    logic                w_res_z;
    logic                w_alu_we;
    logic                w_jump;
    logic [ADDR_W-1:0]   w_pc_next;

    assign w_op  = r_ir[DATA_W+3:DATA_W];
    assign w_imm = r_ir[DATA_W-1:0];

    // ALU: ops 3..A write A and both flags; everything else leaves them alone
    always_comb begin
        w_sum    = '0;
        w_res    = r_a;
        w_res_c  = r_c;
        w_alu_we = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_sum    = {1'b0, r_a} + {1'b0, r_b};
                w_res    = w_sum[DATA_W-1:0];
                w_res_c  = w_sum[DATA_W];
                w_alu_we = 1'b1;
            end
            OP_SUB: begin
                w_sum    = {1'b0, r_a} - {1'b0, r_b};
                w_res    = w_sum[DATA_W-1:0];
                w_res_c  = w_sum[DATA_W];
                w_alu_we = 1'b1;
            end
            OP_AND: begin
                w_res    = r_a & r_b;
                w_res_c  = 1'b0;
                w_alu_we = 1'b1;
            end
            OP_OR: begin
                w_res    = r_a | r_b;
                w_res_c  = 1'b0;
                w_alu_we = 1'b1;
            end
            OP_XOR: begin
                w_res    = r_a ^ r_b;
                w_res_c  = 1'b0;
                w_alu_we = 1'b1;
            end
            OP_NOT: begin
                w_res    = ~r_a;
                w_res_c  = 1'b0;
                w_alu_we = 1'b1;
            end
            OP_SHL: begin
                w_res    = {r_a[DATA_W-2:0], 1'b0};
                w_res_c  = r_a[DATA_W-1];
                w_alu_we = 1'b1;
            end
            OP_SHR: begin
                w_res    = {1'b0, r_a[DATA_W-1:1]};
                w_res_c  = r_a[0];
                w_alu_we = 1'b1;
            end
            default: begin
                w_res    = r_a;
            end
        endcase
        w_res_z = (w_res == '0);
    end

    // Conditional jumps look at the flags as they stood before this instruction
    always_comb begin
        w_jump = (w_op == OP_JMP) ||
                 ((w_op == OP_JZ) && r_z) ||
                 ((w_op == OP_JC) && r_c);
        w_pc_next = w_jump ? w_imm[ADDR_W-1:0] : r_pc + ADDR_W'(1);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (run || step) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_WAIT;
            S_WAIT:   w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_op == OP_HLT)
                    w_next_state = S_HALT;
                else if (run)
                    w_next_state = S_FETCH;
                else
                    w_next_state = S_IDLE;
            end
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_pc    <= '0;
            r_ir    <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE)
                r_ir <= prog.prog_data;
            if (r_state == S_EXEC) begin
                r_pc <= w_pc_next;
                case (w_op)
                    OP_LDA:  r_a <= w_imm;
                    OP_LDB:  r_b <= w_imm;
                    OP_MOVB: r_b <= r_a;
                    default: begin
                        if (w_alu_we) begin
                            r_a <= w_res;
                            r_c <= w_res_c;
                            r_z <= w_res_z;
                        end
                    end
                endcase
            end
        end
    end

    assign prog.prog_addr = r_pc;
    assign halted         = (r_state == S_HALT);
    assign debug_A        = r_a;
    assign debug_B        = r_b;
    assign debug_PC       = r_pc;
    assign debug_State    = r_state;
    assign debug_flags    = {r_c, r_z};

endmodule
